// File: rtl/lexpander_if.sv
// Sample stream bundle for the downward expander: input sample plus live
// threshold/floor controls, and the gated output sample with its valid strobe.
interface lexpander_if #(
  parameter int W_TOTAL = 16
);
  logic                      i_ce;
  logic signed [W_TOTAL-1:0] i_data;
  logic        [W_TOTAL-1:0] i_threshold;
  logic        [W_TOTAL-1:0] i_floor;
  logic signed [W_TOTAL-1:0] o_data;
  logic                      o_ce;
  logic                      o_gate_open;

  modport master (
    output i_ce, i_data, i_threshold, i_floor,
    input  o_data, o_ce, o_gate_open
  );

  modport slave (
    input  i_ce, i_data, i_threshold, i_floor,
    output o_data, o_ce, o_gate_open
  );
endinterface

// File: rtl/lexpander.sv
// Downward expander / noise gate: Q1.15 samples below threshold are ramped
// toward a floor gain; stage 1 runs the gain FSM, stage 2 applies the gain.
module lexpander #(
  parameter int W_TOTAL      = 16,
  parameter int ATTACK_STEP  = 4096,
  parameter int RELEASE_STEP = 512,
  parameter int HOLD_SAMPLES = 4
) (
  input logic       i_clk,
  input logic       i_reset_n,
  lexpander_if.slave bus
);
  localparam int                 GW      = W_TOTAL + 1;
  localparam int                 CNT_W   = (HOLD_SAMPLES > 1) ? $clog2(HOLD_SAMPLES) : 1;
  localparam bit                 NO_HOLD = (HOLD_SAMPLES == 0);
  localparam logic [W_TOTAL-1:0] UNITY   = {1'b1, {(W_TOTAL-1){1'b0}}};
  localparam logic [W_TOTAL-1:0] MAX_POS = ~UNITY;
  localparam logic [CNT_W-1:0]   HOLD_INIT = CNT_W'((HOLD_SAMPLES > 0) ? HOLD_SAMPLES - 1 : 0);

  typedef enum logic [2:0] {CLOSED, ATTACK, OPEN, HOLD, RELEASE} state_t;

  state_t                    state_reg;
  logic        [W_TOTAL-1:0] gain_reg;
  logic        [CNT_W-1:0]   cnt_reg;
  logic signed [W_TOTAL-1:0] data_s1_reg;
  logic                      open_s1_reg;
  logic                      valid_s1_reg;
  logic signed [W_TOTAL-1:0] out_data_reg;
  logic                      out_ce_reg;
  logic                      out_open_reg;

  logic [W_TOTAL-1:0] mag;
  logic [W_TOTAL-1:0] thr_c;
  logic [W_TOTAL-1:0] floor_c;
  logic [W_TOTAL-1:0] base;
  logic [GW-1:0]      up_raw;
  logic               up_full;
  logic [W_TOTAL-1:0] up_gain;
  logic               rel_done;
  logic [W_TOTAL-1:0] dn_gain;
  logic               above;

  // |-32768| has no positive Q1.15 encoding, so it saturates to full scale.
  always_comb begin
    if (bus.i_data == $signed(UNITY)) begin
      mag = MAX_POS;
    end else if (bus.i_data[W_TOTAL-1]) begin
      mag = W_TOTAL'(-bus.i_data);
    end else begin
      mag = bus.i_data;
    end
  end

  assign thr_c   = bus.i_threshold[W_TOTAL-1] ? '0 : bus.i_threshold;
  assign floor_c = (bus.i_floor > UNITY) ? UNITY : bus.i_floor;
  assign above   = (mag >= thr_c);

  // Attack out of CLOSED starts from the floor; every other state ramps from the held gain.
  assign base     = (state_reg == CLOSED) ? floor_c : gain_reg;
  assign up_raw   = {1'b0, base} + GW'(ATTACK_STEP);
  assign up_full  = (up_raw >= {1'b0, UNITY});
  assign up_gain  = up_full ? UNITY : up_raw[W_TOTAL-1:0];
  assign rel_done = ({1'b0, gain_reg} <= ({1'b0, floor_c} + GW'(RELEASE_STEP)));
  assign dn_gain  = gain_reg - W_TOTAL'(RELEASE_STEP);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg    <= CLOSED;
      gain_reg     <= '0;
      cnt_reg      <= '0;
      data_s1_reg  <= '0;
      open_s1_reg  <= 1'b0;
      valid_s1_reg <= 1'b0;
    end else begin
      valid_s1_reg <= bus.i_ce;
      if (bus.i_ce) begin
        data_s1_reg <= bus.i_data;
        case (state_reg)
          CLOSED: begin
            if (above) begin
              gain_reg    <= up_gain;
              state_reg   <= up_full ? OPEN : ATTACK;
              open_s1_reg <= up_full;
            end else begin
              gain_reg    <= floor_c;
              open_s1_reg <= 1'b0;
            end
          end
          ATTACK: begin
            gain_reg    <= up_gain;
            state_reg   <= up_full ? OPEN : ATTACK;
            open_s1_reg <= up_full;
          end
          OPEN, HOLD: begin
            if (above) begin
              gain_reg    <= UNITY;
              state_reg   <= OPEN;
              open_s1_reg <= 1'b1;
            end else if ((state_reg == OPEN) && !NO_HOLD) begin
              gain_reg    <= UNITY;
              state_reg   <= HOLD;
              cnt_reg     <= HOLD_INIT;
              open_s1_reg <= 1'b1;
            end else if ((state_reg == HOLD) && (cnt_reg != '0)) begin
              cnt_reg     <= cnt_reg - CNT_W'(1);
              open_s1_reg <= 1'b1;
            end else begin
              gain_reg    <= rel_done ? floor_c : dn_gain;
              state_reg   <= rel_done ? CLOSED : RELEASE;
              open_s1_reg <= 1'b0;
            end
          end
          RELEASE: begin
            if (above) begin
              gain_reg    <= up_gain;
              state_reg   <= up_full ? OPEN : ATTACK;
              open_s1_reg <= up_full;
            end else begin
              gain_reg    <= rel_done ? floor_c : dn_gain;
              state_reg   <= rel_done ? CLOSED : RELEASE;
              open_s1_reg <= 1'b0;
            end
          end
          default: begin
            gain_reg    <= '0;
            state_reg   <= CLOSED;
            open_s1_reg <= 1'b0;
          end
        endcase
      end
    end
  end

  // Gain never exceeds unity, so the floored product always fits the sample width.
  logic signed [2*W_TOTAL:0]  prod;
  logic signed [W_TOTAL-1:0]  scaled;
  assign prod   = data_s1_reg * $signed({1'b0, gain_reg});
  assign scaled = W_TOTAL'(prod >>> (W_TOTAL - 1));

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      out_data_reg <= '0;
      out_ce_reg   <= 1'b0;
      out_open_reg <= 1'b0;
    end else begin
      out_ce_reg <= valid_s1_reg;
      if (valid_s1_reg) begin
        out_data_reg <= scaled;
        out_open_reg <= open_s1_reg;
      end
    end
  end

  assign bus.o_data      = out_data_reg;
  assign bus.o_ce        = out_ce_reg;
  assign bus.o_gate_open = out_open_reg;
endmodule

// File: tb/tb_lexpander.sv
// Directed bench for lexpander: hand-computed gain ramps checked with
// immediate assertions, one line per mismatching transaction.
module tb_lexpander;
  logic i_clk;
  logic i_reset_n;

  lexpander_if #(.W_TOTAL(16)) bus ();

  lexpander #(
    .W_TOTAL(16), .ATTACK_STEP(4096), .RELEASE_STEP(512), .HOLD_SAMPLES(4)
  ) dut (
    .i_clk(i_clk),
    .i_reset_n(i_reset_n),
    .bus(bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int          checks   = 0;
  int          failures = 0;
  int          step_no  = 0;
  logic        prev_ce  = 1'b0;
  logic [15:0] pend_d   = '0;
  logic        pend_o   = 1'b0;
  logic [15:0] last_d   = '0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s step=%0d obs=%h exp=%h", tag, step_no, obs, exp);
    end
  endtask

  // Drive one cycle; the sample presented on the previous tick must appear now.
  task automatic tick(input logic ce, input logic [15:0] d,
                      input logic [15:0] ed, input logic eo);
    bus.i_ce   = ce;
    bus.i_data = d;
    @(posedge i_clk);
    #1;
    step_no++;
    chk("o_ce", {15'd0, bus.o_ce}, {15'd0, prev_ce});
    if (prev_ce) begin
      chk("o_data", bus.o_data, pend_d);
      chk("o_gate_open", {15'd0, bus.o_gate_open}, {15'd0, pend_o});
      last_d = pend_d;
    end else begin
      chk("o_data_hold", bus.o_data, last_d);
    end
    prev_ce = ce;
    pend_d  = ed;
    pend_o  = eo;
  endtask

  task automatic clear_model();
    prev_ce = 1'b0;
    last_d  = '0;
  endtask

  initial begin
    i_reset_n       = 1'b0;
    bus.i_ce        = 1'b0;
    bus.i_data      = 16'h4000;
    bus.i_threshold = 16'h1000;
    bus.i_floor     = 16'h0000;

    // Reset held while i_ce toggles: outputs stay zero
    for (int i = 0; i < 4; i++) begin
      bus.i_ce = ~bus.i_ce;
      @(posedge i_clk);
      #1;
      chk("rst_o_data", bus.o_data, 16'h0000);
      chk("rst_o_ce", {15'd0, bus.o_ce}, 16'h0000);
      chk("rst_gate", {15'd0, bus.o_gate_open}, 16'h0000);
    end
    bus.i_ce  = 1'b0;
    i_reset_n = 1'b1;
    clear_model();
    tick(1'b0, 16'h0000, 16'h0000, 1'b0);

    // Closed gate, floor 0
    for (int i = 0; i < 4; i++) tick(1'b1, 16'h0100, 16'h0000, 1'b0);

    // Attack: 8 samples to unity
    for (int i = 1; i <= 8; i++) tick(1'b1, 16'h4000, 16'(i * 16'h0800), (i == 8));

    // Hold 4 samples at unity, then 64-step release to floor 0
    for (int i = 0; i < 4; i++) tick(1'b1, 16'h0100, 16'h0100, 1'b1);
    for (int j = 1; j <= 64; j++) tick(1'b1, 16'h0100, 16'((32768 - 512 * j) >> 7), 1'b0);

    // Threshold at full scale: -32768 still opens via saturated magnitude
    bus.i_threshold = 16'h7FFF;
    tick(1'b1, 16'h7FFE, 16'h0000, 1'b0);
    for (int i = 1; i <= 8; i++) tick(1'b1, 16'h8000, 16'(-4096 * i), (i == 8));
    tick(1'b1, 16'h8000, 16'h8000, 1'b1);
    tick(1'b1, 16'h7FFF, 16'h7FFF, 1'b1);

    // Negative threshold behaves as 0: everything counts as above
    bus.i_threshold = 16'hF000;
    tick(1'b1, 16'h0000, 16'h0000, 1'b1);
    tick(1'b1, 16'h0001, 16'h0001, 1'b1);

    // Floor beyond unity clamps to 0x8000: release lands on unity immediately
    bus.i_threshold = 16'h1000;
    bus.i_floor     = 16'hFFFF;
    for (int i = 0; i < 4; i++) tick(1'b1, 16'h0100, 16'h0100, 1'b1);
    tick(1'b1, 16'h0100, 16'h0100, 1'b0);
    tick(1'b1, 16'h0100, 16'h0100, 1'b0);

    // Nonzero floor: closed gain tracks floor, attack starts from floor
    bus.i_floor = 16'h2000;
    tick(1'b1, 16'h0100, 16'h0040, 1'b0);
    tick(1'b1, 16'h4000, 16'h1800, 1'b0);
    tick(1'b1, 16'h4000, 16'h2000, 1'b0);
    tick(1'b1, 16'h4000, 16'h2800, 1'b0);
    tick(1'b1, 16'h4000, 16'h3000, 1'b0);
    tick(1'b1, 16'h4000, 16'h3800, 1'b0);
    tick(1'b1, 16'h4000, 16'h4000, 1'b1);

    // Release with i_ce every third cycle: one step per accepted sample
    bus.i_floor = 16'h0000;
    for (int i = 0; i < 4; i++) tick(1'b1, 16'h0100, 16'h0100, 1'b1);
    for (int j = 1; j <= 4; j++) begin
      tick(1'b1, 16'h0100, 16'((32768 - 512 * j) >> 7), 1'b0);
      tick(1'b0, 16'h0100, 16'h0000, 1'b0);
      tick(1'b0, 16'h0100, 16'h0000, 1'b0);
    end

    // Reset mid-release, with one sample in flight
    tick(1'b1, 16'h0100, 16'h00EC, 1'b0);
    i_reset_n = 1'b0;
    bus.i_ce  = 1'b0;
    #1;
    step_no++;
    chk("midrst_o_data", bus.o_data, 16'h0000);
    chk("midrst_o_ce", {15'd0, bus.o_ce}, 16'h0000);
    chk("midrst_gate", {15'd0, bus.o_gate_open}, 16'h0000);
    @(posedge i_clk);
    #1;
    i_reset_n = 1'b1;
    clear_model();

    // Back in CLOSED: attack starts from floor 0x2000, not from a release gain
    bus.i_floor = 16'h2000;
    tick(1'b1, 16'h4000, 16'h1800, 1'b0);
    tick(1'b0, 16'h0000, 16'h0000, 1'b0);
    tick(1'b0, 16'h0000, 16'h0000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lexpander.md
Name: lexpander

Overview:
- Downward expander / noise gate; the complement of the limiter/compressor in the same Q1.15 audio chain.
- Samples whose magnitude stays below a threshold are attenuated toward a programmable floor gain. Samples above the threshold pass at unity.
- Gain moves by per-sample attack/release ramps with a hold counter, so transitions do not click.
- Sits after the compressor in the sample-enable (i_ce/o_ce) pipeline.

Parameters:
W_TOTAL, 16, sample width (Q1.15 signed)
ATTACK_STEP, 4096, gain increment per accepted sample while attacking (unsigned Q1.15, 0x8000 = 1.0)
RELEASE_STEP, 512, gain decrement per accepted sample while releasing
HOLD_SAMPLES, 4, accepted below-threshold samples kept at unity before release starts (0 = release immediately)

Ports:
i_clk  in  1  clock, rising edge
i_reset_n  in  1  asynchronous, active-low reset
i_ce  in  1  sample enable; one sample accepted per high cycle
i_data  in  W_TOTAL  signed Q1.15 input sample
i_threshold  in  W_TOTAL  signed Q1.15 open threshold; only 0..0x7FFF is meaningful, negative values are treated as 0
i_floor  in  W_TOTAL  unsigned Q1.15 closed gain; values >0x8000 are clamped to 0x8000
o_data  out  W_TOTAL  signed Q1.15 output sample (registered)
o_ce  out  1  output valid, i_ce delayed exactly 2 cycles
o_gate_open  out  1  high while state is OPEN or HOLD (registered, aligned with o_ce/o_data)

Behaviour:
- Reset (async assert, sync deassert by the clock domain):
  - o_data=0, o_ce=0, o_gate_open=0.
  - state=CLOSED, gain=0, hold counter=0.
  - All pipeline valid bits cleared. Reset mid-ramp aborts the ramp.
- Stage 1, on i_ce:
  - Register i_data.
  - Compute mag=|i_data|, with |-32768| saturated to 0x7FFF.
  - above = (mag >= threshold).
  - Update the FSM and gain register.
- Stage 2:
  - o_data = (data_s1 * gain) >>> 15, signed×unsigned, 33-bit product, arithmetic shift (floor rounding).
  - Since gain <= 0x8000, the result always fits W_TOTAL, so no saturation logic is needed.
  - gain==0x8000 is exact passthrough, including -32768.
- Latency and alignment:
  - Latency is 2 clocks, i_ce to o_ce.
  - The gain computed for sample n is the gain applied to sample n.
  - o_data holds its value when o_ce=0.
- Without i_ce, nothing advances: state, gain, and hold counter are frozen. Back-to-back i_ce every cycle is supported.
- FSM transitions, evaluated only on i_ce:
  - CLOSED: gain <= floor (tracks i_floor every sample). above -> ATTACK, with gain <= min(floor+ATTACK_STEP, 0x8000).
  - ATTACK: gain <= min(gain+ATTACK_STEP, 0x8000); the new gain reaching 0x8000 -> OPEN. Attack is committed: below samples do not interrupt it.
  - OPEN: gain=0x8000. above -> stay. below -> HOLD with cnt=HOLD_SAMPLES-1; if HOLD_SAMPLES==0, go directly to RELEASE and apply the first decrement on this sample.
  - HOLD: gain=0x8000. above -> OPEN. below with cnt==0 -> RELEASE. Otherwise cnt--.
  - RELEASE: gain <= max(gain-RELEASE_STEP, floor); reaching floor -> CLOSED. above -> ATTACK, increment applied from the current gain on this sample.
- Ramp arithmetic uses 17-bit intermediates so there is no wrap-around at either bound.
- If the floor rises above the current gain during RELEASE, gain jumps to the floor and the state goes to CLOSED.
- Threshold/floor changes are sampled on each i_ce; no stability is required.

Test Plan:
- Reset: hold i_reset_n=0 with i_ce toggling -> o_data=0, o_ce=0, o_gate_open=0. Release reset; the first o_ce arrives 2 cycles after the first i_ce.
- Closed gate: threshold=0x1000, floor=0, i_data=0x0100 every cycle -> o_data=0x0000, o_gate_open=0.
- Attack: step i_data to 0x4000 -> successive o_data 0x0800, 0x1000, …, 0x4000 (8 samples); o_gate_open rises on the 8th output.
- Hold/release: drop i_data to 0x0100 -> 4 outputs of 0x0100 (unity); then gain 32256, 31744, … (o_data 0x00FC, 0x00F8, …); reaches 0 after 64 samples; o_gate_open=0.
- Extremes: open gate, i_data=0x8000 (-32768) -> o_data=0x8000 exactly. threshold=0x7FFF opens on -32768 (saturated magnitude).
- Enable gaps / reset: i_ce asserted every 3rd cycle mid-release -> gain steps once per accepted sample; o_ce is exactly 2 cycles after each i_ce. Assert i_reset_n=0 mid-release -> outputs 0 immediately; state returns to CLOSED.
